// File: rtl/rv32_types.sv
//------------------------------------------------------------------------------
// rv32_types
// Shared RV32 datapath types: register ids, data words, the register-file
// write request and the per-unit retiring result (wb_result_t).
// Ports: none (package).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv32_types;

  localparam int RV_XLEN     = 32;
  localparam int RV_NUM_REGS = 32;

  typedef logic [4:0]         rv_reg_id_t;
  typedef logic [RV_XLEN-1:0] rv32_word;

  // One write toward the register file's single write port.
  typedef struct packed {
    logic       write;
    rv_reg_id_t id;
    rv32_word   data;
  } register_write_request_t;

  // A result retiring from an execution unit.
  typedef struct packed {
    rv_reg_id_t id;
    rv32_word   data;
  } wb_result_t;

  // One-hot register mask for a destination id.
  function automatic logic [RV_NUM_REGS-1:0] reg_bit(input rv_reg_id_t id);
    return RV_NUM_REGS'(1) << id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_rr_arbiter.sv
//------------------------------------------------------------------------------
// rv32_rr_arbiter
// Round-robin arbiter: request vector in, at most one one-hot grant out.
// The search starts at rr_ptr and wraps; after a grant to w the pointer
// moves to w+1 (mod NUM_REQ), so the last winner has lowest priority.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   req           request vector
//   grant         one-hot grant (all zero when nothing requests)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rv32_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic             any_grant;

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    sum       = '0;
    idx       = '0;
    grant     = '0;
    next_ptr  = rr_ptr;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Candidate index (rr_ptr + k) mod NUM_REQ; both terms are < NUM_REQ,
      // so a single conditional subtract is enough.
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = (idx == PTR_W'(NUM_REQ-1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= next_ptr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32_writeback_arbiter.sv
//------------------------------------------------------------------------------
// rv32_writeback_arbiter
// Producer side of the register file's single write port. Buffers one
// retiring result per execution unit, arbitrates round-robin and emits one
// register_write_request_t per cycle. Publishes a pending-destination mask
// for the decode stage's hazard stall.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   src_valid       producer i presents a result
//   src_result      {id, data} per producer
//   src_ready       producer i is accepted at the next rising edge if valid
//   write_request   {write, id, data} toward the register file
//   pending_mask    bit r set while a write to xr is buffered or in flight
//   busy            any buffer or the output register is occupied
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

import rv32_types::*;

module rv32_writeback_arbiter #(
  parameter int NUM_SOURCES = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_SOURCES-1:0]  src_valid,
  input  wb_result_t              src_result [NUM_SOURCES],
  output logic [NUM_SOURCES-1:0]  src_ready,
  output register_write_request_t write_request,
  output logic [31:0]             pending_mask,
  output logic                    busy
);

  logic [NUM_SOURCES-1:0] buf_valid;
  wb_result_t             buf_entry [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] discard;
  logic [NUM_SOURCES-1:0] grant;
  wb_result_t             winner;

  // Writes to x0 are architecturally void: such entries never compete and
  // are dropped at the next edge instead.
  always_comb begin
    req     = '0;
    discard = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      req[i]     = buf_valid[i] && (buf_entry[i].id != '0);
      discard[i] = buf_valid[i] && (buf_entry[i].id == '0);
    end
  end

  rv32_rr_arbiter #(
    .NUM_REQ (NUM_SOURCES)
  ) u_rr_arbiter (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .grant  (grant)
  );

  // A draining entry (granted or discarded) frees its slot for a refill on
  // the same edge. Depends on state only, so producers see no comb path.
  assign src_ready = ~buf_valid | grant | discard;

  // Grant is one-hot, so a priority-free select is exact.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant[i]) begin
        winner = buf_entry[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        buf_entry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          buf_valid[i] <= 1'b1;
          buf_entry[i] <= src_result[i];
        end else if (grant[i] || discard[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // id/data hold on idle cycles; only the write strobe is cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write_request <= '0;
    end else if (|grant) begin
      write_request <= '{write: 1'b1, id: winner.id, data: winner.data};
    end else begin
      write_request.write <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (req[i]) begin
        pending_mask = pending_mask | reg_bit(buf_entry[i].id);
      end
    end
    if (write_request.write) begin
      pending_mask = pending_mask | reg_bit(write_request.id);
    end
    pending_mask[0] = 1'b0;
  end

  assign busy = (|buf_valid) || write_request.write;

endmodule

`default_nettype wire

// File: tb/tb_rv32_writeback_arbiter.sv
//------------------------------------------------------------------------------
// tb_rv32_writeback_arbiter
// Self-checking bench: directed vector table, hand-written fairness and
// mid-cycle reset sequences, and randomized traffic against a reference
// model of the writeback rules.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv32_writeback_arbiter;
  import rv32_types::*;

  localparam int N = 3;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic [N-1:0]            src_valid;
  wb_result_t              src_result [N];
  logic [N-1:0]            src_ready;
  register_write_request_t write_request;
  logic [31:0]             pending_mask;
  logic                    busy;

  int checks = 0;
  int failures = 0;

  rv32_writeback_arbiter #(.NUM_SOURCES(N)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .src_valid     (src_valid),
    .src_result    (src_result),
    .src_ready     (src_ready),
    .write_request (write_request),
    .pending_mask  (pending_mask),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_bv  [N];
  rv_reg_id_t m_id  [N];
  rv32_word   m_dat [N];
  int         m_ptr;
  logic       m_w;
  rv_reg_id_t m_wid;
  rv32_word   m_wdat;
  logic [N-1:0] m_acc;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bv[i] = 1'b0; m_id[i] = '0; m_dat[i] = '0;
    end
    m_ptr = 0; m_w = 1'b0; m_wid = '0; m_wdat = '0; m_acc = '0;
  endtask

  // First eligible buffer (valid, id != 0) scanning from the pointer.
  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (m_bv[i] && m_id[i] != 5'd0) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int w;
    w = model_winner();
    for (int i = 0; i < N; i++) r[i] = !m_bv[i] || (w == i) || (m_id[i] == 5'd0);
    return r;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (m_bv[i] && m_id[i] != 5'd0) m[m_id[i]] = 1'b1;
    if (m_w) m[m_wid] = 1'b1;
    return m;
  endfunction

  function automatic logic model_busy();
    logic b;
    b = m_w;
    for (int i = 0; i < N; i++) b = b | m_bv[i];
    return b;
  endfunction

  task automatic model_tick();
    int w;
    logic [N-1:0] r;
    w = model_winner();
    r = model_ready();
    m_acc = src_valid & r;
    if (w >= 0) begin
      m_w = 1'b1; m_wid = m_id[w]; m_wdat = m_dat[w]; m_ptr = (w + 1) % N;
    end else begin
      m_w = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (i == w || (m_bv[i] && m_id[i] == 5'd0)) m_bv[i] = 1'b0;
      if (m_acc[i]) begin
        m_bv[i] = 1'b1; m_id[i] = src_result[i].id; m_dat[i] = src_result[i].data;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".write"}, write_request.write, m_w);
    chk({tag, ".id"},    write_request.id,    m_wid);
    chk({tag, ".data"},  write_request.data,  m_wdat);
    chk({tag, ".mask"},  pending_mask,        model_mask());
    chk({tag, ".ready"}, src_ready,           model_ready());
    chk({tag, ".busy"},  busy,                model_busy());
  endtask

  logic [N-1:0]            obs_ready;
  register_write_request_t obs_wr;

  // Check at the falling edge, then drive inputs for the next rising edge.
  task automatic drive_cycle(input string tag, input logic [N-1:0] v,
                             input logic [N-1:0][4:0] ids, input logic [N-1:0][31:0] dats);
    @(negedge clk);
    compare_model(tag);
    obs_ready = src_ready;
    obs_wr    = write_request;
    src_valid = v;
    for (int i = 0; i < N; i++) src_result[i] = '{id: ids[i], data: dats[i]};
    @(posedge clk);
    model_tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    src_valid = '0;
    for (int i = 0; i < N; i++) src_result[i] = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic               pre_reset;
    logic [N-1:0]       v;
    logic [N-1:0][4:0]  ids;
    logic [N-1:0][31:0] dats;
    logic               e_write;
    logic [4:0]         e_id;
    logic [31:0]        e_data;
    logic [31:0]        e_mask;
    logic [N-1:0]       e_ready;
    logic               e_busy;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic pr, input logic [N-1:0] v,
                              input logic [N-1:0][4:0] ids, input logic [N-1:0][31:0] dats,
                              input logic ew, input logic [4:0] eid, input logic [31:0] ed,
                              input logic [31:0] em, input logic [N-1:0] er, input logic eb);
    vec_t t;
    t.pre_reset = pr; t.v = v; t.ids = ids; t.dats = dats;
    t.e_write = ew; t.e_id = eid; t.e_data = ed; t.e_mask = em; t.e_ready = er; t.e_busy = eb;
    return t;
  endfunction

  localparam logic [31:0] DBF = 32'hDEADBEEF;
  localparam logic [31:0] D1 = 32'hC0DE0001, D2 = 32'hC0DE0002, D3 = 32'hC0DE0003;
  localparam logic [31:0] D4 = 32'hC0DE0004, D6 = 32'hC0DE0006;

  initial begin
    src_valid = '0;
    for (int i = 0; i < N; i++) src_result[i] = '0;
    model_reset();

    // Rows: inputs applied this cycle; expectations are the outputs seen
    // in this cycle before those inputs reach an edge.
    // single source
    tbl[0]  = mk(1, 3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, DBF}, 0, 0, 0,   32'h0,  3'b111, 0);
    tbl[1]  = mk(0, 3'b000, '0, '0,                                   0, 0, 0,   32'h20, 3'b111, 1);
    tbl[2]  = mk(0, 3'b000, '0, '0,                                   1, 5, DBF, 32'h20, 3'b111, 1);
    tbl[3]  = mk(0, 3'b000, '0, '0,                                   0, 5, DBF, 32'h0,  3'b111, 0);
    // full contention, ids 1,2,3
    tbl[4]  = mk(1, 3'b111, {5'd3, 5'd2, 5'd1}, {D3, D2, D1},        0, 0, 0,   32'h0,  3'b111, 0);
    tbl[5]  = mk(0, 3'b000, '0, '0,                                   0, 0, 0,   32'hE,  3'b001, 1);
    tbl[6]  = mk(0, 3'b000, '0, '0,                                   1, 1, D1,  32'hE,  3'b011, 1);
    tbl[7]  = mk(0, 3'b000, '0, '0,                                   1, 2, D2,  32'hC,  3'b111, 1);
    tbl[8]  = mk(0, 3'b000, '0, '0,                                   1, 3, D3,  32'h8,  3'b111, 1);
    // pointer back at 0: src0 must beat src1
    tbl[9]  = mk(0, 3'b011, {5'd0, 5'd6, 5'd4}, {32'd0, D6, D4},      0, 3, D3,  32'h0,  3'b111, 0);
    tbl[10] = mk(0, 3'b000, '0, '0,                                   0, 3, D3,  32'h50, 3'b101, 1);
    tbl[11] = mk(0, 3'b000, '0, '0,                                   1, 4, D4,  32'h50, 3'b111, 1);
    // x0 discard from src1
    tbl[12] = mk(0, 3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd1, 32'd0},1, 6, D6,  32'h40, 3'b111, 1);
    tbl[13] = mk(0, 3'b000, '0, '0,                                   0, 6, D6,  32'h0,  3'b111, 1);
    tbl[14] = mk(0, 3'b000, '0, '0,                                   0, 6, D6,  32'h0,  3'b111, 0);

    for (int r = 0; r < 15; r++) begin
      string tag;
      tag = $sformatf("vec%0d", r);
      if (tbl[r].pre_reset) do_reset();
      @(negedge clk);
      chk({tag, ".write"}, write_request.write, tbl[r].e_write);
      chk({tag, ".id"},    write_request.id,    tbl[r].e_id);
      chk({tag, ".data"},  write_request.data,  tbl[r].e_data);
      chk({tag, ".mask"},  pending_mask,        tbl[r].e_mask);
      chk({tag, ".ready"}, src_ready,           tbl[r].e_ready);
      chk({tag, ".busy"},  busy,                tbl[r].e_busy);
      src_valid = tbl[r].v;
      for (int i = 0; i < N; i++) src_result[i] = '{id: tbl[r].ids[i], data: tbl[r].dats[i]};
    end

    // ---------------- fairness: src0 streams, src2 sends once ----------------
    do_reset();
    begin
      int s0, low, wr20;
      s0 = 10; low = 0; wr20 = -1;
      for (int c = 0; c < 8; c++) begin
        logic [N-1:0]       v;
        logic [N-1:0][4:0]  ids;
        logic [N-1:0][31:0] ds;
        v = (c == 1) ? 3'b101 : 3'b001;
        ids = '0; ds = '0;
        ids[0] = 5'(s0); ids[2] = 5'd20;
        ds[0] = 32'hF0000000 + 32'(s0); ds[2] = 32'h20202020;
        drive_cycle("fair", v, ids, ds);
        if (!obs_ready[0]) low++;
        if (obs_wr.write && obs_wr.id == 5'd20 && wr20 < 0) wr20 = c;
        if (m_acc[0]) s0++;
      end
      chk("fair.src0_ready_low_cycles", 64'(low), 64'd1);
      chk("fair.src2_accept_to_write", 64'(wr20 - 1), 64'd2);
    end

    // ---------------- reset mid-operation ----------------
    do_reset();
    drive_cycle("rm", 3'b111, {5'd11, 5'd9, 5'd8}, {32'hB, 32'h9, 32'h8});
    drive_cycle("rm", 3'b000, '0, '0);
    #2;
    chk("rm.pre_write", write_request.write, 1'b1);
    chk("rm.pre_mask",  pending_mask, 32'h00000B00);
    resetn = 1'b0;
    #1;
    chk("rm.async_write", write_request.write, 1'b0);
    chk("rm.async_mask",  pending_mask, 32'h0);
    chk("rm.async_busy",  busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) drive_cycle("rm_after", 3'b000, '0, '0);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0]       v;
      logic [N-1:0][4:0]  ids;
      logic [N-1:0][31:0] ds;
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ids[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
        ds[i]  = $urandom;
      end
      drive_cycle("rand", v, ids, ds);
    end
    for (int c = 0; c < 6; c++) drive_cycle("drain", 3'b000, '0, '0);
    @(negedge clk);
    chk("drain.busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
